// File: rtl/sine_pkg.sv
// Shared constants for the sine PWM generator.
// Widths and the sine table offset/amplitude.
package sine_pkg;

  localparam int PWM_WIDTH_DEF  = 8;
  localparam int ADDR_WIDTH_DEF = 8;
  localparam int SINE_OFFSET    = 128;
  localparam int SINE_AMPL      = 127;

endpackage

// File: rtl/sine_rom.sv
// Sine sample ROM, combinational read.
// Built from a quarter-wave table, round(127*sin(2*pi*k/256)).
module sine_rom
  import sine_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int PWM_WIDTH  = PWM_WIDTH_DEF
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [PWM_WIDTH-1:0]  data_o
);

  // Quarter-wave magnitudes for k = 0..64 (256-entry full wave).
  localparam logic [6:0] QTAB [0:64] = '{
    7'd0,   7'd3,   7'd6,   7'd9,   7'd12,
    7'd16,  7'd19,  7'd22,  7'd25,  7'd28,
    7'd31,  7'd34,  7'd37,  7'd40,  7'd43,
    7'd46,  7'd49,  7'd51,  7'd54,  7'd57,
    7'd60,  7'd63,  7'd65,  7'd68,  7'd71,
    7'd73,  7'd76,  7'd78,  7'd81,  7'd83,
    7'd85,  7'd88,  7'd90,  7'd92,  7'd94,
    7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
    7'd106, 7'd107, 7'd109, 7'd111, 7'd112,
    7'd113, 7'd115, 7'd116, 7'd117, 7'd118,
    7'd120, 7'd121, 7'd122, 7'd122, 7'd123,
    7'd124, 7'd125, 7'd125, 7'd126, 7'd126,
    7'd126, 7'd127, 7'd127, 7'd127, 7'd127
  };

  logic [7:0] k;
  logic [1:0] quad;
  logic [6:0] off;
  logic [6:0] qidx;
  logic [6:0] mag;
  logic [7:0] smp;

  assign k    = 8'(addr_i);
  assign quad = k[7:6];
  assign off  = {1'b0, k[5:0]};

  // Fold the address onto the quarter wave and apply the sign.
  always_comb begin
    qidx = off;
    if (quad[0]) begin
      qidx = 7'd64 - off;
    end
    mag = QTAB[qidx];
    smp = 8'(SINE_OFFSET) + {1'b0, mag};
    if (quad[1]) begin
      smp = 8'(SINE_OFFSET) - {1'b0, mag};
    end
  end

  assign data_o = PWM_WIDTH'(smp);

endmodule

// File: rtl/sine_pwm_gen.sv
// Sine generator as a single-bit PWM stream.
// Counter, sample address, duty latch and comparator.
module sine_pwm_gen
  import sine_pkg::*;
#(
  parameter int PWM_WIDTH  = PWM_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic clk_100,
  input  logic rst,
  output logic sine
);

  logic [PWM_WIDTH-1:0]  cnt_q, cnt_d;
  logic [PWM_WIDTH-1:0]  duty_q, duty_d;
  logic [PWM_WIDTH-1:0]  rom_data;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic                  sine_q, sine_d;
  logic                  period_end;

  assign period_end = (cnt_q == '1);
  assign rom_addr   = addr_q + 1'b1;

  sine_rom #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .PWM_WIDTH (PWM_WIDTH)
  ) u_rom (
    .addr_i(rom_addr),
    .data_o(rom_data)
  );

  // Next state: free-running counter, duty reloads only at period end.
  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    addr_d = addr_q;
    duty_d = duty_q;
    if (period_end) begin
      addr_d = rom_addr;
      duty_d = rom_data;
    end
    sine_d = (cnt_q < duty_q);
  end

  // State registers, async reset to phase 0.
  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      addr_q <= '0;
      duty_q <= PWM_WIDTH'(SINE_OFFSET);
      sine_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      duty_q <= duty_d;
      sine_q <= sine_d;
    end
  end

  assign sine = sine_q;

endmodule

// File: tb/tb_sine_pwm_gen.sv
// Scoreboard bench for sine_pwm_gen.
// Expected per-period high counts come from a real-valued sine model.
module tb_sine_pwm_gen;

  logic clk_100 = 1'b0;
  logic rst     = 1'b1;
  logic sine;

  sine_pwm_gen dut (
    .clk_100(clk_100),
    .rst    (rst),
    .sine   (sine)
  );

  // 100 MHz clock model: 10 time-unit period, 50% duty.
  always #5 clk_100 = ~clk_100;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_q[$];
  bit mon_en = 1'b0;

  int win_pos, win_hi, win_cnt, tot_hi, model_total;
  bit seen_low, first_hi, shape_ok;

  function automatic int lut_model(input int k);
    real v;
    v = 128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * k / 256.0);
    return int'($floor(v + 0.5));
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic clear_window();
    win_pos  = 0;
    win_hi   = 0;
    seen_low = 0;
    first_hi = 0;
    shape_ok = 1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_sine"}, int'(sine), 0);
    check({tag, "_cnt"}, int'(dut.cnt_q), 0);
    check({tag, "_addr"}, int'(dut.addr_q), 0);
  endtask

  task automatic release_and_expect(input int nwin);
    @(negedge clk_100);
    #1;
    rst = 1'b0;
    clear_window();
    win_cnt = 0;
    tot_hi  = 0;
    exp_q.delete();
    for (int w = 0; w < nwin; w++) exp_q.push_back(lut_model(w % 256));
    mon_en = 1'b1;
  endtask

  // Monitor: one sample per clock, one scoreboard pop per PWM period.
  initial begin
    int e;
    clear_window();
    win_cnt = 0;
    tot_hi  = 0;
    forever begin
      @(negedge clk_100);
      if (mon_en) begin
        if (sine) begin
          win_hi++;
          if (win_pos == 0) first_hi = 1;
          if (seen_low) shape_ok = 0;
        end else begin
          seen_low = 1;
        end
        win_pos++;
        if (win_pos == 256) begin
          if (exp_q.size() == 0) begin
            check("queue_underrun", win_cnt, -1);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("high_count_p%0d", win_cnt), win_hi, e);
            check($sformatf("shape_p%0d", win_cnt),
                  int'(shape_ok && (first_hi || e == 0)), 1);
          end
          tot_hi += win_hi;
          win_cnt++;
          if (win_cnt == 256) check("full_period_total", tot_hi, model_total);
          clear_window();
        end
      end
    end
  end

  // Stimulus: reset, a full sine period plus one, async reset, restart.
  initial begin
    int r;
    model_total = 0;
    for (int k = 0; k < 256; k++) model_total += lut_model(k);

    rst = 1'b1;
    repeat (5) @(posedge clk_100);
    @(negedge clk_100);
    check_reset_state("reset");

    release_and_expect(257);
    repeat (257 * 256) @(posedge clk_100);
    r = $urandom_range(1, 120);
    repeat (r) @(posedge clk_100);
    #($urandom_range(1, 4));
    check("pre_reset_sine_high", int'(sine), 1);
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_state("async_reset");

    repeat ($urandom_range(2, 6)) @(posedge clk_100);
    @(negedge clk_100);
    check_reset_state("held_reset");

    release_and_expect(2);
    repeat (513) @(posedge clk_100);
    @(negedge clk_100);
    #1;
    mon_en = 1'b0;
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
